// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, FSM states and control width.
// Imported by the ALU decoder and the execute-stage ALU.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1011
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } alu_state_t;

  function automatic logic is_shift(
    input logic [ALU_CTRL_W-1:0] c
  );
    return (c == ALU_SLL) ||
           (c == ALU_SRL) ||
           (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_multicycle_shift_step.sv
// One bounded shift step for the iterative shifter.
// Right shifts fill with the sign bit when arith is set.
module alu_shift_step #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 1
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dir,
  input  logic             i_arith,
  input  logic [AMT_W-1:0] i_amount,
  output logic [WIDTH-1:0] o_value
);

  // Select left, logical-right or arithmetic-right shift
  always_comb begin
    o_value = i_value;
    if (!i_dir) begin
      o_value = i_value << i_amount;
    end else if (i_arith) begin
      o_value = $signed(i_value) >>> i_amount;
    end else begin
      o_value = i_value >> i_amount;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops,
// iterative shifts, valid/ready on both sides.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  negative,
  output logic                  carry,
  output logic                  overflow,
  output logic                  illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int AMT_W   = $clog2(SHIFT_STEP + 1);
  localparam int M       = WIDTH - 1;

  alu_state_t         r_state;
  alu_state_t         w_next;
  alu_op_t            r_op;
  logic [SHAMT_W-1:0] r_rem;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_ovf;
  logic               r_ill;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH:0]     w_sum;
  logic               w_ovf;
  logic               w_lt;
  logic               w_ltu;
  logic [WIDTH-1:0]   w_alu;
  logic               w_c;
  logic               w_v;
  logic               w_legal;
  logic [AMT_W-1:0]   w_amt;
  logic               w_last;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_done;

  assign w_accept = in_valid & in_ready;
  assign w_shamt  = src_b[SHAMT_W-1:0];

  assign w_sub   = (alu_control == ALU_SUB);
  assign w_b_eff = w_sub ? ~src_b : src_b;
  assign w_sum   = {1'b0, src_a}
                 + {1'b0, w_b_eff}
                 + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf   = (src_a[M] == w_b_eff[M]) &&
                   (w_sum[M] != src_a[M]);
  assign w_lt    = $signed(src_a) < $signed(src_b);
  assign w_ltu   = src_a < src_b;

  // Decode the op into the value captured at accept
  always_comb begin
    w_alu   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_legal = 1'b1;
    case (alu_control)
      ALU_ADD,
      ALU_SUB: begin
        w_alu = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      ALU_AND:  w_alu = src_a & src_b;
      ALU_OR:   w_alu = src_a | src_b;
      ALU_XOR:  w_alu = src_a ^ src_b;
      ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_ltu};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  w_alu = src_a;
      default:  w_legal = 1'b0;
    endcase
  end

  // Clamp this cycle's shift to what remains
  always_comb begin
    if (int'(r_rem) > SHIFT_STEP) begin
      w_amt = AMT_W'(SHIFT_STEP);
    end else begin
      w_amt = AMT_W'(r_rem);
    end
  end

  assign w_last = (r_rem == SHAMT_W'(w_amt));

  alu_shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_step (
    .i_value  (r_result),
    .i_dir    (r_op != ALU_SLL),
    .i_arith  (r_op == ALU_SRA),
    .i_amount (w_amt),
    .o_value  (w_shifted)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (is_shift(alu_control) &&
              (w_shamt != '0)) begin
            w_next = SHIFT;
          end else begin
            w_next = DONE;
          end
        end
      end
      SHIFT: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture operands at accept, iterate shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= ALU_ADD;
      r_rem    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= alu_op_t'(alu_control);
            r_rem    <= w_shamt;
            r_result <= w_alu;
            r_carry  <= w_c;
            r_ovf    <= w_v;
            r_ill    <= ~w_legal;
          end
        end
        SHIFT: begin
          r_result <= w_shifted;
          r_rem    <= r_rem - SHAMT_W'(w_amt);
        end
        default: ;
      endcase
    end
  end

  assign w_done    = (r_state == DONE);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = w_done;
  assign result    = r_result;
  assign zero      = w_done & (r_result == '0);
  assign negative  = w_done & r_result[M];
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign illegal   = r_ill;

endmodule
